// File: rtl/axi_mem_responder.sv
// ============================================================================
// Module  : axi_mem_responder
// Brief   : AXI4 INCR-burst slave backed by a word-addressed register memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_mem_responder #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [AXI_ID_WIDTH-1:0]     awid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]                  awlen_i,
    input  logic                        awvalid_i,
    output logic                        awready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                        wlast_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    output logic [AXI_ID_WIDTH-1:0]     bid_o,
    output logic [1:0]                  bresp_o,
    output logic                        bvalid_o,
    input  logic                        bready_i,
    input  logic [AXI_ID_WIDTH-1:0]     arid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]                  arlen_i,
    input  logic                        arvalid_i,
    output logic                        arready_o,
    output logic [AXI_ID_WIDTH-1:0]     rid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]                  rresp_o,
    output logic                        rlast_o,
    output logic                        rvalid_o,
    input  logic                        rready_i
);

    localparam int BPW  = AXI_DATA_WIDTH / 8;
    localparam int OFFW = $clog2(BPW);
    localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_INC = AXI_ADDR_WIDTH'(BPW);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A  = AXI_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ---------------- write engine ----------------
    wstate_e                   wstate_q;
    logic                      awready_q, wready_q, bvalid_q, werr_q;
    logic [AXI_ID_WIDTH-1:0]   wid_q, bid_q;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]                wlen_q, wcnt_q;
    logic [1:0]                bresp_q;

    logic [AXI_ADDR_WIDTH-1:0] widx;
    logic                      w_in_range, w_final_beat, w_beat_err, w_mem_we;

    assign widx         = waddr_q >> OFFW;
    assign w_in_range   = (widx < DEPTH_A);
    assign w_final_beat = (wcnt_q == wlen_q);
    assign w_beat_err   = !w_in_range || (wlast_i != w_final_beat);
    assign w_mem_we     = (wstate_q == W_DATA) && wvalid_i && w_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (awvalid_i) begin
                        wid_q     <= awid_i;
                        waddr_q   <= awaddr_i;
                        wlen_q    <= awlen_i;
                        wcnt_q    <= 8'd0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid_i) begin
                        waddr_q <= waddr_q + ADDR_INC;
                        wcnt_q  <= wcnt_q + 8'd1;
                        if (w_beat_err) begin
                            werr_q <= 1'b1;
                        end
                        // Burst length comes from awlen only; wlast merely flags errors.
                        if (w_final_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            bresp_q  <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < BPW; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx[IDXW-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read engine ----------------
    rstate_e                   rstate_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [AXI_ID_WIDTH-1:0]   rid_q;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]                rlen_q, rcnt_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;

    logic [AXI_ADDR_WIDTH-1:0] rsrc_addr, ridx;
    logic                      r_in_range;
    logic [AXI_DATA_WIDTH-1:0] rword;

    // raddr_q always points at the beat to be loaded on the next R handshake.
    assign rsrc_addr  = (rstate_q == R_IDLE) ? araddr_i : raddr_q;
    assign ridx       = rsrc_addr >> OFFW;
    assign r_in_range = (ridx < DEPTH_A);
    assign rword      = r_in_range ? mem_q[ridx[IDXW-1:0]] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arvalid_i) begin
                        rid_q     <= arid_i;
                        rlen_q    <= arlen_i;
                        rcnt_q    <= 8'd0;
                        raddr_q   <= araddr_i + ADDR_INC;
                        rdata_q   <= rword;
                        rresp_q   <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                        rlast_q   <= (arlen_i == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + 8'd1;
                            raddr_q <= raddr_q + ADDR_INC;
                            rdata_q <= rword;
                            rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign bvalid_o  = bvalid_q;
    assign arready_o = arready_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;
    assign rvalid_o  = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
// ============================================================================
// Module  : tb_axi_mem_responder
// Brief   : Scoreboard testbench for axi_mem_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_mem_responder;

    localparam int MEM_DEPTH = 1024;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  awid_i = '0;
    logic [31:0] awaddr_i = '0;
    logic [7:0]  awlen_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wlast_i = 1'b0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [7:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b0;
    logic [7:0]  arid_i = '0;
    logic [31:0] araddr_i = '0;
    logic [7:0]  arlen_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [7:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i = 1'b0;

    axi_mem_responder #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [7:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct {logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] model[int];
    logic [31:0] wdat[16];
    logic [3:0]  wstb[16];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the B handshake.
    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input int wlast_at);
        logic [31:0] a = addr;
        logic        err = 1'b0;
        int          guard;
        b_exp_t      e;
        for (int i = 0; i <= int'(len); i++) begin
            int  idx = int'(a >> 2);
            logic wl = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
            if (wl != (i == int'(len))) err = 1'b1;
            if (idx >= MEM_DEPTH) begin
                err = 1'b1;
            end else begin
                logic [31:0] w = model.exists(idx) ? model[idx] : 32'hxxxxxxxx;
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) w[8*b +: 8] = wdat[i][8*b +: 8];
                model[idx] = w;
            end
            a = a + 32'd4;
        end
        b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

        awid_i = id; awaddr_i = addr; awlen_i = len; awvalid_i = 1'b1;
        guard = 0;
        while (!awready_o && guard < 50) begin @(negedge clk_i); guard++; end
        if (guard >= 50) chk("aw_timeout", 1, 0);
        @(negedge clk_i);
        awvalid_i = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata_i  = wdat[i];
            wstrb_i  = wstb[i];
            wlast_i  = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
            wvalid_i = 1'b1;
            guard = 0;
            while (!wready_o && guard < 50) begin @(negedge clk_i); guard++; end
            if (guard >= 50) chk("w_timeout", 1, 0);
            @(negedge clk_i);
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
        chk("bvalid_after_last_w", bvalid_o, 1);
        guard = 0;
        while (!bvalid_o && guard < 50) begin @(negedge clk_i); guard++; end
        if (bvalid_o && b_q.size() > 0) begin
            e = b_q.pop_front();
            chk("bid", bid_o, e.id);
            chk("bresp", bresp_o, e.resp);
        end else begin
            chk("b_timeout", 1, 0);
        end
        bready_i = 1'b1;
        @(negedge clk_i);
        bready_i = 1'b0;
        chk("bvalid_clear", bvalid_o, 0);
    endtask

    // stall_at: beat index before which rready is held low for stall_len cycles.
    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int stall_at, input int stall_len);
        logic [31:0] a = addr;
        int          guard, beats, stalls;
        r_exp_t      e;
        for (int i = 0; i <= int'(len); i++) begin
            int idx = int'(a >> 2);
            if (idx >= MEM_DEPTH)
                r_q.push_back('{id: id, data: 32'h0, resp: 2'b10, last: (i == int'(len))});
            else
                r_q.push_back('{id: id, data: model[idx], resp: 2'b00, last: (i == int'(len))});
            a = a + 32'd4;
        end

        arid_i = id; araddr_i = addr; arlen_i = len; arvalid_i = 1'b1;
        guard = 0;
        while (!arready_o && guard < 50) begin @(negedge clk_i); guard++; end
        if (guard >= 50) chk("ar_timeout", 1, 0);
        @(negedge clk_i);
        arvalid_i = 1'b0;

        beats = 0; stalls = 0; guard = 0;
        while (beats <= int'(len) && guard < 500) begin
            if (beats == stall_at && stalls < stall_len) begin
                rready_i = 1'b0;
                stalls++;
                if (rvalid_o && r_q.size() > 0) begin
                    chk("rdata_hold", rdata_o, r_q[0].data);
                    chk("rlast_hold", rlast_o, r_q[0].last);
                end
            end else begin
                rready_i = 1'b1;
                if (rvalid_o) begin
                    if (r_q.size() > 0) begin
                        e = r_q.pop_front();
                        chk("rid", rid_o, e.id);
                        chk("rdata", rdata_o, e.data);
                        chk("rresp", rresp_o, e.resp);
                        chk("rlast", rlast_o, e.last);
                    end else begin
                        chk("r_extra_beat", 1, 0);
                    end
                    beats++;
                end
            end
            @(negedge clk_i);
            guard++;
        end
        rready_i = 1'b0;
        chk("r_beat_count", beats, int'(len) + 1);
        chk("rvalid_clear", rvalid_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_awready", awready_o, 1);
        chk("rst_arready", arready_o, 1);
        chk("rst_wready", wready_o, 0);
        chk("rst_bvalid", bvalid_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rlast", rlast_o, 0);
        chk("rst_bresp", bresp_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h11111111 * (i + 1); wstb[i] = 4'hF; end
        axi_write(8'h05, 32'h100, 8'd3, -1);
        axi_read(8'h06, 32'h100, 8'd3, -1, 0);

        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
        axi_write(8'h01, 32'h200, 8'd0, -1);
        wdat[0] = 32'h00000000; wstb[0] = 4'h5;
        axi_write(8'h02, 32'h200, 8'd0, -1);
        axi_read(8'h03, 32'h200, 8'd0, -1, 0);

        for (int i = 0; i < 8; i++) begin wdat[i] = 32'hC0DE0000 + 32'(i * 32'h101); wstb[i] = 4'hF; end
        axi_write(8'h07, 32'h400, 8'd7, -1);
        axi_read(8'h08, 32'h400, 8'd7, 3, 3);

        wdat[0] = 32'hCAFEF00D; wdat[1] = 32'h12345678; wstb[0] = 4'hF; wstb[1] = 4'hF;
        axi_write(8'h0A, 32'((MEM_DEPTH - 1) * 4), 8'd1, -1);
        axi_read(8'h0B, 32'((MEM_DEPTH - 1) * 4), 8'd1, -1, 0);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h5A5A0000 + 32'(i); wstb[i] = 4'hF; end
        axi_write(8'h0C, 32'h700, 8'd3, 2);
        axi_read(8'h0D, 32'h700, 8'd3, -1, 0);

        // Reset mid-burst: AW and AR accepted together, two beats each, then reset.
        awid_i = 8'h20; awaddr_i = 32'h500; awlen_i = 8'd3; awvalid_i = 1'b1;
        arid_i = 8'h21; araddr_i = 32'h100; arlen_i = 8'd3; arvalid_i = 1'b1;
        @(negedge clk_i);
        awvalid_i = 1'b0; arvalid_i = 1'b0;
        chk("mid_wready", wready_o, 1);
        chk("mid_rvalid", rvalid_o, 1);
        rready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wdata_i = 32'hBEEF0000 + 32'(i); wstrb_i = 4'hF; wlast_i = 1'b0; wvalid_i = 1'b1;
            model[(32'h500 >> 2) + i] = 32'hBEEF0000 + 32'(i);
            @(negedge clk_i);
        end
        rst_ni = 1'b0; wvalid_i = 1'b0; rready_i = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid_o, 0);
        chk("mid_rst_bvalid", bvalid_o, 0);
        chk("mid_rst_awready", awready_o, 1);
        chk("mid_rst_arready", arready_o, 1);
        chk("mid_rst_wready", wready_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_bvalid", bvalid_o, 0);
        axi_read(8'h22, 32'h500, 8'd1, -1, 0);
        wdat[0] = 32'h600D0001; wdat[1] = 32'h600D0002; wstb[0] = 4'hF; wstb[1] = 4'hF;
        axi_write(8'h23, 32'h600, 8'd1, -1);
        axi_read(8'h24, 32'h600, 8'd1, -1, 0);

        chk("b_queue_empty", b_q.size(), 0);
        chk("r_queue_empty", r_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
